// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the keypad scanner.
// The optional auto-repeat feature is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } keypad_state_t;

    // Row drive after reset: row 0 pulled low first.
    localparam logic [3:0] ROW_INIT = 4'b1110;

    // One column sample reduced to a key code; 'none' covers zero or several low columns.
    typedef struct packed {
        logic       none;
        logic [3:0] code;
    } key_sample_t;

    localparam key_sample_t KEY_NONE = '{none: 1'b1, code: 4'd0};

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } line_idx_t;

    // One-hot-low line vector to bit index; valid only when exactly one line is low.
    function automatic line_idx_t col_to_idx(input logic [3:0] lines);
        line_idx_t res;
        res.valid = 1'b1;
        res.idx   = 2'd0;
        case (lines)
            4'b1110: res.idx = 2'd0;
            4'b1101: res.idx = 2'd1;
            4'b1011: res.idx = 2'd2;
            4'b0111: res.idx = 2'd3;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

    // Keypad legend: row 0 / col 0 is key 15, row 3 / col 3 is key 0.
    function automatic logic [3:0] rc_to_code(input logic [1:0] r, input logic [1:0] c);
        return 4'd15 - {r, 2'b00} - {2'b00, c};
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Row dwell counter: produces a one-cycle sample strobe every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    output logic strobe
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign strobe = (cnt == LAST);

    // Count up to the end of the dwell, then wrap to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debouncing.
// key_valid is a one-cycle event with no back-pressure: the consumer must take
// key_code in the cycle key_valid is high; key_code stays stable until the next
// accepted press. Define KEYPAD_REPEAT_EN to re-emit key_valid while a key is held.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV         = 250000,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int REPEAT_SAMPLES   = 50
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [3:0]    keypad_col,
    output logic [3:0]    keypad_row,
    output logic [3:0]    key_code,
    output logic          key_valid,
    output logic          key_held,
    output keypad_state_t state_dbg
);

    localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_SAMPLES);

    keypad_state_t state, state_n;
    logic [3:0]    col_meta, col_sync;
    logic [3:0]    row_n, cand, cand_n, code_n;
    logic [DW-1:0] match_cnt, match_n, match_inc;
    logic [DW-1:0] rel_cnt, rel_n, rel_inc;
    logic          held_n, emit, strobe;
    line_idx_t     col_idx, row_idx;
    key_sample_t   sample;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_SAMPLES);
    logic [RW-1:0] rep_cnt, rep_n;
`endif

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe)
    );

    assign state_dbg = state;

    // Two-flop synchronizer; idle lines read high (no key).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= keypad_col;
            col_sync <= col_meta;
        end
    end

    // Reduce the current row/column pair to a key sample.
    always_comb begin
        col_idx = col_to_idx(col_sync);
        row_idx = col_to_idx(keypad_row);
        sample  = KEY_NONE;
        if (col_idx.valid) begin
            sample = '{none: 1'b0, code: rc_to_code(row_idx.idx, col_idx.idx)};
        end
    end

    // Saturating increments keep the counters from wrapping.
    assign match_inc = (match_cnt == DMAX) ? DMAX : match_cnt + 1'b1;
    assign rel_inc   = (rel_cnt == DMAX) ? DMAX : rel_cnt + 1'b1;

    // Next-state logic: scan, confirm a press, then confirm its release.
    always_comb begin
        state_n = state;
        row_n   = keypad_row;
        cand_n  = cand;
        code_n  = key_code;
        match_n = match_cnt;
        rel_n   = rel_cnt;
        held_n  = key_held;
        emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_n   = rep_cnt;
`endif
        case (state)
            SCAN: begin
                if (strobe) begin
                    if (!sample.none) begin
                        cand_n  = sample.code;
                        match_n = DW'(1);
                        if (DEBOUNCE_SAMPLES <= 1) begin
                            state_n = PRESSED;
                            code_n  = sample.code;
                            held_n  = 1'b1;
                            emit    = 1'b1;
                            match_n = '0;
                            rel_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_n   = '0;
`endif
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        row_n = {keypad_row[2:0], keypad_row[3]};
                    end
                end
            end
            DEBOUNCE: begin
                if (strobe) begin
                    if (!sample.none && sample.code == cand) begin
                        match_n = match_inc;
                        if (match_inc == DMAX) begin
                            state_n = PRESSED;
                            code_n  = cand;
                            held_n  = 1'b1;
                            emit    = 1'b1;
                            match_n = '0;
                            rel_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_n   = '0;
`endif
                        end
                    end else begin
                        state_n = SCAN;
                        match_n = '0;
                        row_n   = {keypad_row[2:0], keypad_row[3]};
                    end
                end
            end
            PRESSED: begin
                if (strobe) begin
                    if (sample.none) begin
                        rel_n = rel_inc;
`ifdef KEYPAD_REPEAT_EN
                        rep_n = '0;
`endif
                        if (rel_inc == DMAX) begin
                            state_n = SCAN;
                            held_n  = 1'b0;
                            rel_n   = '0;
                            row_n   = {keypad_row[2:0], keypad_row[3]};
                        end
                    end else begin
                        rel_n = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt + 1'b1 == RMAX) begin
                            rep_n = '0;
                            emit  = 1'b1;
                        end else begin
                            rep_n = rep_cnt + 1'b1;
                        end
`endif
                    end
                end
            end
            default: begin
                state_n = SCAN;
                row_n   = ROW_INIT;
            end
        endcase
    end

    // State and datapath registers; key_valid lags the confirming strobe by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SCAN;
            keypad_row <= ROW_INIT;
            cand       <= 4'd0;
            key_code   <= 4'd0;
            match_cnt  <= '0;
            rel_cnt    <= '0;
            key_held   <= 1'b0;
            key_valid  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            keypad_row <= row_n;
            cand       <= cand_n;
            key_code   <= code_n;
            match_cnt  <= match_n;
            rel_cnt    <= rel_n;
            key_held   <= held_n;
            key_valid  <= emit & enable;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt    <= rep_n;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a physical key matrix drives the columns from
// the DUT's row drive; a strobe-level reference model predicts every output.
module tb_keypad_scan_debounce;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b1;
    logic [3:0]    keypad_col;
    logic [3:0]    keypad_row;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_held;
    keypad_state_t state_dbg;
    logic [15:0]   keys = 16'h0;   // bit r*4+c set = key at row r, column c held down

    always #5 clk = ~clk;

    keypad_scan_debounce #(
        .SCAN_DIV         (SCAN_DIV),
        .DEBOUNCE_SAMPLES (DEB),
        .REPEAT_SAMPLES   (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .keypad_col (keypad_col),
        .keypad_row (keypad_row),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .state_dbg  (state_dbg)
    );

    // Matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        keypad_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keypad_row[r] == 1'b0 && keys[r*4+c]) keypad_col[c] = 1'b0;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model (one step per sample strobe) ----------------
    int         m_row, m_phase, m_cand, m_streak, m_rel, m_rep, m_div;
    logic [3:0] e_code;
    logic       e_held, e_valid;

    task automatic model_reset();
        m_row = 0; m_phase = 0; m_cand = 0; m_streak = 0; m_rel = 0; m_rep = 0; m_div = 0;
        e_code = 4'd0; e_held = 1'b0; e_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept();
        e_code  = 4'(m_cand);
        e_held  = 1'b1;
        m_phase = 2;
        m_rel   = 0;
        m_rep   = 0;
        if (enable) begin
            e_valid = 1'b1;
            exp_q.push_back(4'(m_cand));
        end
    endtask

    task automatic model_strobe();
        int  cnt, col, code;
        bit  have;
        cnt = 0; col = 0;
        for (int c = 0; c < 4; c++)
            if (keys[m_row*4+c]) begin cnt++; col = c; end
        have = (cnt == 1);
        code = 15 - 4*m_row - col;
        case (m_phase)
            0: if (have) begin
                   m_cand = code; m_streak = 1; m_phase = 1;
               end else m_row = (m_row + 1) % 4;
            1: if (have && code == m_cand) begin
                   m_streak++;
                   if (m_streak >= DEB) model_accept();
               end else begin
                   m_phase = 0; m_row = (m_row + 1) % 4;
               end
            default: if (!have) begin
                   m_rel++; m_rep = 0;
                   if (m_rel >= DEB) begin
                       e_held = 1'b0; m_phase = 0; m_rel = 0; m_row = (m_row + 1) % 4;
                   end
               end else begin
                   m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
                   m_rep++;
                   if (m_rep == REP) begin
                       m_rep = 0;
                       if (enable) begin e_valid = 1'b1; exp_q.push_back(e_code); end
                   end
`endif
               end
        endcase
    endtask

    // Advance the model over the coming rising edge.
    task automatic model_edge();
        e_valid = 1'b0;
        if (m_div == SCAN_DIV - 1) model_strobe();
        m_div = (m_div + 1) % SCAN_DIV;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_row;
        exp_row = 4'hF;
        exp_row[m_row] = 1'b0;
        check("row", keypad_row, exp_row);
        check("code", key_code, e_code);
        check("held", key_held, e_held);
        check("valid", key_valid, e_valid);
        check("state", state_dbg, m_phase);
        if (key_valid) pulses++;
        if (e_valid && exp_q.size() > 0) check("pulse_code", key_code, exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_strobes(input int n);
        repeat (n * SCAN_DIV) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_row", keypad_row, ROW_INIT);
        check("rst_code", key_code, 4'd0);
        check("rst_held", key_held, 1'b0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_state", state_dbg, SCAN);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_key(input int r, input int c, input bit down);
        keys[r*4+c] = down;
    endtask

    // ---------------- stimulus ----------------
    int p0, r, c;

    initial begin
        repeat (3) @(negedge clk);
        do_reset();

        // Key 9 held for 20 strobes, then released.
        p0 = pulses;
        set_key(1, 2, 1);
        run_strobes(20);
        set_key(1, 2, 0);
        run_strobes(2);
        check("s1_held_pending", key_held, 1'b1);
        run_strobes(4);
        check("s1_pulses", pulses - p0, 1);
        check("s1_code", key_code, 4'd9);
        check("s1_released", key_held, 1'b0);

        // Single-strobe glitch on the row currently being scanned.
        p0 = pulses;
        c  = $urandom_range(0, 3);
        r  = m_row;
        set_key(r, c, 1);
        run_strobes(1);
        set_key(r, c, 0);
        run_strobes(3);
        check("s2_pulses", pulses - p0, 0);

        // Two keys in row 0 (col 1100) held together.
        p0 = pulses;
        set_key(0, 0, 1); set_key(0, 1, 1);
        run_strobes(10);
        set_key(0, 0, 0); set_key(0, 1, 0);
        run_strobes(2);
        check("s3_pulses", pulses - p0, 0);

        // Press while disabled, enable mid-hold, release and press again.
        p0 = pulses;
        enable = 1'b0;
        set_key(3, 3, 1);
        run_strobes(8);
        check("s4_held_disabled", key_held, 1'b1);
        enable = 1'b1;
        run_strobes(5);
        check("s4_no_pulse", pulses - p0, 0);
        set_key(3, 3, 0);
        run_strobes(5);
        set_key(3, 3, 1);
        run_strobes(8);
        set_key(3, 3, 0);
        run_strobes(5);
        check("s4_pulses", pulses - p0, 1);
        check("s4_code", key_code, 4'd0);

        // Reset in the middle of a press; key stays down through reset.
        set_key(2, 1, 1);
        run_strobes(8);
        check("s5_pressed", state_dbg, PRESSED);
        do_reset();
        p0 = pulses;
        run_strobes(2);
        check("s5_no_early_pulse", pulses - p0, 0);
        run_strobes(6);
        check("s5_redebounced", pulses - p0, 1);
        check("s5_code", key_code, 4'd6);
        set_key(2, 1, 0);
        run_strobes(5);

        // Key 15 held from a fresh reset for 3 + 12 strobes.
        do_reset();
        p0 = pulses;
        set_key(0, 0, 1);
        run_strobes(15);
`ifdef KEYPAD_REPEAT_EN
        check("s6_pulses", pulses - p0, 3);
`else
        check("s6_pulses", pulses - p0, 1);
`endif
        check("s6_code", key_code, 4'd15);
        set_key(0, 0, 0);
        run_strobes(5);

        // Randomized presses with contact bounce, chords and enable changes.
        for (int ep = 0; ep < 30; ep++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 3)) begin
                set_key(r, c, 1);
                run_strobes($urandom_range(1, 2));
                set_key(r, c, 0);
                run_strobes($urandom_range(0, 1));
            end
            set_key(r, c, 1);
            run_strobes($urandom_range(2, 12));
            if ($urandom_range(0, 4) == 0) begin
                set_key($urandom_range(0, 3), $urandom_range(0, 3), 1);
                run_strobes($urandom_range(1, 4));
            end
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            run_strobes($urandom_range(0, 4));
            keys = 16'h0;
            if ($urandom_range(0, 2) == 0) begin
                run_strobes(1);
                set_key(r, c, 1);
                run_strobes(1);
                keys = 16'h0;
            end
            run_strobes($urandom_range(2, 6));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Scans the 4x4 matrix keypad, debounces presses and emits one validated key code per physical press.
- Sits upstream of the hit-detection logic: key_code/key_valid are compared there against the current mole position (rand).
- Keypad timing and the row-scan loop leave the hit logic; it consumes clean single-cycle events only.

Parameters:
- SCAN_DIV, 250000: clk cycles per row dwell; one column sample strobe at the end of each dwell.
- DEBOUNCE_SAMPLES, 3: consecutive matching samples required to accept a press, and to accept a release.
- REPEAT_SAMPLES, 50: samples between auto-repeat events (used only with KEYPAD_REPEAT_EN).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  game active (driven by !overFlow); gates key_valid only.
- keypad_col  in  4  raw column lines, active-low, asynchronous to clk.
- keypad_row  out  4  row drive, one-hot-low.
- key_code  out  4  accepted key code; held until the next accepted press.
- key_valid  out  1  one-cycle pulse per accepted press.
- key_held  out  1  high from acceptance until debounced release.

Behaviour:
- Reset values: keypad_row=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters=0.
- keypad_col passes through a 2-flop synchronizer before any use.
- Sample strobe: fires when the dwell counter reaches SCAN_DIV-1; the counter then wraps to 0.
- Row index r: the bit of keypad_row driven low (1110 -> r=0).
- Column index c: the bit of the synchronized columns that is low.
- Key code: code = 15 - 4*r - c. Examples: row 1110 / col 1110 -> 15; row 0111 / col 0111 -> 0.
- Valid sample: exactly one column is low. Zero or multiple low columns count as "none".
- SCAN state:
  - On each strobe, a valid sample latches the candidate code, sets match count to 1 and moves to DEBOUNCE. The row does not advance.
  - Otherwise the row rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- DEBOUNCE state:
  - Row is frozen.
  - A strobe with the same code increments the match count.
  - A strobe with a different code or "none" returns to SCAN and advances the row.
  - When the match count reaches DEBOUNCE_SAMPLES, go to PRESSED.
  - On that transition: key_code <= candidate, key_held <= 1, and key_valid pulses in the next cycle if enable=1.
- PRESSED state:
  - Row is frozen.
  - A strobe reading "none" increments the release count; any other reading, including a different key in the same row, clears it.
  - When the release count reaches DEBOUNCE_SAMPLES: key_held <= 0, go to SCAN, advance the row.
- enable=0: the FSM runs normally but key_valid is forced 0.
  - A press accepted while enable=0 never produces a pulse, including after enable rises.
  - The next pulse requires release plus a new press.
- Latency: key_valid follows the final confirming strobe by exactly 1 cycle.
  - Worst case from a stable press to pulse: 2 + (4 + DEBOUNCE_SAMPLES - 1)*SCAN_DIV + 1 cycles.
- Counter widths:
  - Dwell counter: $clog2(SCAN_DIV) bits.
  - Match and release counters: saturate at DEBOUNCE_SAMPLES; no wrap.
- Async reset during any state restores all reset values immediately; no pulse is emitted.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: while in PRESSED with no release sample pending, every REPEAT_SAMPLES strobes re-emits a key_valid pulse (gated by enable) with an unchanged key_code. The repeat counter clears on entering PRESSED and on any release sample.
- Undefined: exactly one key_valid per press; the REPEAT_SAMPLES parameter is unused.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, PRESSED};
  - ROW_INIT = 4'b1110;
  - KEY_NONE marker;
  - function col_to_idx (one-hot-low to index plus valid flag);
  - function rc_to_code.
- One sub-module, keypad_tick_gen: the dwell counter that produces the sample strobe. Parameter SCAN_DIV; ports clk, rst, strobe.

Test Plan (SCAN_DIV=4, DEBOUNCE_SAMPLES=3):
- Hold col=1011 whenever row=1101, release after 20 strobes -> exactly one key_valid; key_code=9; key_held high until 3 "none" strobes after release; row resumes rotating.
- Key low for 1 strobe, then released -> no key_valid; FSM returns to SCAN; row advances to next.
- Row 1110 with col=1100 (two keys) held 10 strobes -> no key_valid; row keeps rotating.
- enable=0, press row 0111 / col 0111, raise enable while held -> no pulse; release, re-press -> one pulse, key_code=0.
- Assert rst low mid-PRESSED -> keypad_row=1110, key_held=0, key_valid=0 same cycle; no pulse after rst rises with key still held until it is debounced anew.
- KEYPAD_REPEAT_EN, REPEAT_SAMPLES=5, key 15 held 3+12 strobes -> pulses at acceptance, +5, +10 strobes (3 total); key_code=15 throughout.
